// File: rtl/dmem_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
// Port ids double as the bit index of each requester in req/gnt vectors.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_id_e;

endpackage

// File: rtl/rr_burst_arb.sv
// Two-way burst-limited round-robin grant logic with owner and burst counter.
// The counter saturates at MAX_BURST; the owner only loses a tie once it gets there.
module rr_burst_arb
  import dmem_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output port_id_e   gnt_port
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  port_id_e         owner;
  logic [CNT_W-1:0] cnt;

  // Combinational grant decision from the request pair, owner and burst count
  always_comb begin
    gnt      = 2'b00;
    gnt_port = PORT_C;
    case (req)
      2'b01: begin
        gnt      = 2'b01;
        gnt_port = PORT_C;
      end
      2'b10: begin
        gnt      = 2'b10;
        gnt_port = PORT_D;
      end
      2'b11: begin
        if (cnt < BURST_LIM) begin
          gnt_port = owner;
        end else if (owner == PORT_C) begin
          gnt_port = PORT_D;
        end else begin
          gnt_port = PORT_C;
        end
        if (gnt_port == PORT_D) begin
          gnt = 2'b10;
        end else begin
          gnt = 2'b01;
        end
      end
      default: begin
        gnt      = 2'b00;
        gnt_port = PORT_C;
      end
    endcase
  end

  // Owner/burst-count update; an idle cycle ends the burst but keeps ownership
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= PORT_C;
      cnt   <= CNT_ZERO;
    end else if (gnt == 2'b00) begin
      owner <= owner;
      cnt   <= CNT_ZERO;
    end else if (gnt_port == owner) begin
      owner <= owner;
      if (cnt < BURST_LIM) begin
        cnt <= cnt + CNT_ONE;
      end else begin
        cnt <= cnt;
      end
    end else begin
      owner <= gnt_port;
      cnt   <= CNT_ONE;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer between the core (C) and debug loader (D) ports of a
// single-port data memory; read data returns one cycle after grant.
module dmem_arbiter #(
  parameter int DATA_W    = dmem_pkg::DATA_W,
  parameter int ADDR_W    = dmem_pkg::ADDR_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [DATA_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);
  import dmem_pkg::*;

  localparam logic [DATA_W-ADDR_W-1:0] ADDR_PAD = {(DATA_W-ADDR_W){1'b0}};

  logic [1:0] gnt;
  port_id_e   gnt_port;
  logic       c_rd_hit;
  logic       d_rd_hit;

  rr_burst_arb #(
    .MAX_BURST(MAX_BURST)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({d_req, c_req}),
    .gnt     (gnt),
    .gnt_port(gnt_port)
  );

  assign c_gnt    = gnt[0];
  assign d_gnt    = gnt[1];
  assign c_rd_hit = gnt[0] & ~c_we;
  assign d_rd_hit = gnt[1] & ~d_we;

  // Memory-side mux: only the granted port reaches the memory, idle drives zeros
  always_comb begin
    mem_access_addr = {DATA_W{1'b0}};
    mem_write_data  = {DATA_W{1'b0}};
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    if (gnt != 2'b00) begin
      case (gnt_port)
        PORT_C: begin
          mem_access_addr = {ADDR_PAD, c_addr};
          mem_write_data  = c_wdata;
          mem_write_en    = c_we;
          mem_read        = ~c_we;
        end
        PORT_D: begin
          mem_access_addr = {ADDR_PAD, d_addr};
          mem_write_data  = d_wdata;
          mem_write_en    = d_we;
          mem_read        = ~d_we;
        end
        default: begin
          mem_access_addr = {DATA_W{1'b0}};
          mem_write_data  = {DATA_W{1'b0}};
          mem_write_en    = 1'b0;
          mem_read        = 1'b0;
        end
      endcase
    end else begin
      mem_access_addr = {DATA_W{1'b0}};
      mem_write_data  = {DATA_W{1'b0}};
      mem_write_en    = 1'b0;
      mem_read        = 1'b0;
    end
  end

  // Read return: capture data for the granted reader; the other port's rdata is held
  always_ff @(posedge clk) begin
    if (rst) begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= {DATA_W{1'b0}};
      d_rdata  <= {DATA_W{1'b0}};
    end else begin
      c_rvalid <= c_rd_hit;
      d_rvalid <= d_rd_hit;
      if (c_rd_hit) begin
        c_rdata <= mem_read_data;
      end else begin
        c_rdata <= c_rdata;
      end
      if (d_rd_hit) begin
        d_rdata <= mem_read_data;
      end else begin
        d_rdata <= d_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural memory, a shadow copy for expected
// data and per-port read queues checked when rvalid pulses.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [2:0]  c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read;

  logic [31:0] mem    [8];
  logic [31:0] shadow [8];
  logic [31:0] c_q[$];
  logic [31:0] d_q[$];
  logic [31:0] c_last, d_last;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(3), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  // Data memory: combinational read, write on the rising edge
  assign mem_read_data = mem[mem_access_addr[2:0]];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_access_addr[2:0]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_c(input logic req, input logic we, input logic [2:0] addr, input logic [31:0] wd);
    c_req = req; c_we = we; c_addr = addr; c_wdata = wd;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [2:0] addr, input logic [31:0] wd);
    d_req = req; d_we = we; d_addr = addr; d_wdata = wd;
  endtask

  // One cycle with the grant the bench expects; called right after a negedge
  task automatic tick(input string tag, input logic eg_c, input logic eg_d);
    logic rv_c, rv_d;
    logic [31:0] v;
    rv_c = 1'b0;
    rv_d = 1'b0;
    #2;
    check({tag, ".c_gnt"}, {31'd0, c_gnt}, {31'd0, eg_c});
    check({tag, ".d_gnt"}, {31'd0, d_gnt}, {31'd0, eg_d});
    if (eg_c) begin
      check({tag, ".addr"}, mem_access_addr, {29'd0, c_addr});
      check({tag, ".we"}, {31'd0, mem_write_en}, {31'd0, c_we});
      check({tag, ".rd"}, {31'd0, mem_read}, {31'd0, !c_we});
      if (c_we) begin
        check({tag, ".wdata"}, mem_write_data, c_wdata);
        shadow[c_addr] = c_wdata;
      end else begin
        c_q.push_back(shadow[c_addr]);
        rv_c = 1'b1;
      end
    end else if (eg_d) begin
      check({tag, ".addr"}, mem_access_addr, {29'd0, d_addr});
      check({tag, ".we"}, {31'd0, mem_write_en}, {31'd0, d_we});
      check({tag, ".rd"}, {31'd0, mem_read}, {31'd0, !d_we});
      if (d_we) begin
        check({tag, ".wdata"}, mem_write_data, d_wdata);
        shadow[d_addr] = d_wdata;
      end else begin
        d_q.push_back(shadow[d_addr]);
        rv_d = 1'b1;
      end
    end else begin
      check({tag, ".idle_bus"}, mem_access_addr | mem_write_data, 32'd0);
      check({tag, ".idle_ctl"}, {30'd0, mem_write_en, mem_read}, 32'd0);
    end
    @(posedge clk);
    #1;
    check({tag, ".c_rvalid"}, {31'd0, c_rvalid}, {31'd0, rv_c});
    check({tag, ".d_rvalid"}, {31'd0, d_rvalid}, {31'd0, rv_d});
    if (rv_c && c_q.size() > 0) begin
      v = c_q.pop_front();
      c_last = v;
    end
    if (rv_d && d_q.size() > 0) begin
      v = d_q.pop_front();
      d_last = v;
    end
    check({tag, ".c_rdata"}, c_rdata, c_last);
    check({tag, ".d_rdata"}, d_rdata, d_last);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    set_c(1'b0, 1'b0, 3'd0, 32'd0);
    set_d(1'b0, 1'b0, 3'd0, 32'd0);
    repeat (n) @(posedge clk);
    #1;
    check("rst.rvalid", {30'd0, c_rvalid, d_rvalid}, 32'd0);
    check("rst.c_rdata", c_rdata, 32'd0);
    check("rst.d_rdata", d_rdata, 32'd0);
    check("rst.mem_ctl", {30'd0, mem_write_en, mem_read}, 32'd0);
    check("rst.mem_addr", mem_access_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    c_q.delete();
    d_q.delete();
    c_last = 32'd0;
    d_last = 32'd0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem[i]    = 32'h1111_1111 * i;
      shadow[i] = 32'h1111_1111 * i;
    end
    @(negedge clk);
    do_reset(2);
    tick("idle", 1'b0, 1'b0);

    // C write then read-back of the same address
    set_c(1'b1, 1'b1, 3'd5, 32'hDEAD_BEEF);
    tick("c_wr", 1'b1, 1'b0);
    set_c(1'b1, 1'b0, 3'd5, 32'd0);
    tick("c_rd", 1'b1, 1'b0);
    set_c(1'b0, 1'b0, 3'd0, 32'd0);
    tick("c_post", 1'b0, 1'b0);
    check("c_rdata_val", c_rdata, 32'hDEAD_BEEF);

    // Contention from reset: C x4, D x4, then C again
    do_reset(1);
    set_c(1'b1, 1'b0, 3'd5, 32'd0);
    set_d(1'b1, 1'b0, 3'd1, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick("cont", (i < 4) || (i >= 8), (i >= 4) && (i < 8));
    end

    // Lone D requester well past the burst limit, then C cuts in at once
    set_c(1'b0, 1'b0, 3'd0, 32'd0);
    set_d(1'b1, 1'b0, 3'd2, 32'd0);
    for (int i = 0; i < 10; i++) tick("lone_d", 1'b0, 1'b1);
    set_c(1'b1, 1'b0, 3'd3, 32'd0);
    tick("c_cut_in", 1'b1, 1'b0);
    set_c(1'b0, 1'b0, 3'd0, 32'd0);
    tick("d_resume", 1'b0, 1'b1);

    // D writes, C reads the same word the next cycle
    set_d(1'b1, 1'b1, 3'd7, 32'h1234_5678);
    tick("d_wr", 1'b0, 1'b1);
    set_d(1'b0, 1'b0, 3'd0, 32'd0);
    set_c(1'b1, 1'b0, 3'd7, 32'd0);
    tick("c_rd7", 1'b1, 1'b0);
    set_c(1'b0, 1'b0, 3'd0, 32'd0);
    tick("x_post", 1'b0, 1'b0);
    check("c_rd7_val", c_rdata, 32'h1234_5678);

    // Make D the owner, then reset during a C read grant
    set_d(1'b1, 1'b0, 3'd4, 32'd0);
    tick("d_own", 1'b0, 1'b1);
    tick("d_own", 1'b0, 1'b1);
    set_d(1'b0, 1'b0, 3'd0, 32'd0);
    set_c(1'b1, 1'b0, 3'd5, 32'd0);
    rst = 1'b1;
    #2;
    check("midrst.c_gnt", {31'd0, c_gnt}, 32'd1);
    @(posedge clk);
    #1;
    check("midrst.c_rvalid", {31'd0, c_rvalid}, 32'd0);
    check("midrst.c_rdata", c_rdata, 32'd0);
    check("midrst.d_rdata", d_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    c_q.delete();
    d_q.delete();
    c_last = 32'd0;
    d_last = 32'd0;
    set_c(1'b1, 1'b0, 3'd6, 32'd0);
    set_d(1'b1, 1'b0, 3'd0, 32'd0);
    for (int i = 0; i < 5; i++) tick("post_rst", i < 4, i == 4);
    set_c(1'b0, 1'b0, 3'd0, 32'd0);
    set_d(1'b0, 1'b0, 3'd0, 32'd0);
    tick("final", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
